// File: rtl/up_down_step_gen_if.sv
// Target/step bundle between a step generator and its controller.
// Carries the target request, abort, step pulses and position mirror.
interface up_down_step_gen_if #(
    parameter int N     = 32,
    parameter int GAP_W = 8
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [N-1:0]     tgt;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             up;
    logic             down;
    logic [N-1:0]     pos;
    logic             busy;
    logic             done;

    modport master (
        output tgt_valid, tgt, gap, abort,
        input  tgt_ready, up, down, pos, busy, done
    );

    modport slave (
        input  tgt_valid, tgt, gap, abort,
        output tgt_ready, up, down, pos, busy, done
    );
endinterface

// File: rtl/up_down_step_gen.sv
// Walks an up/down counter toward a target with gapped step pulses.
// Ports: clk, rst (async high), bus = target request in, up/down/pos/busy/done out.
module up_down_step_gen #(
    parameter int N     = 32,
    parameter int GAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    up_down_step_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pos_q, pos_d;
    logic [N-1:0]     tgt_q, tgt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] cnt_q, cnt_d;

    logic up_w;
    logic down_w;
    logic ready_w;
    logic busy_w;
    logic done_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tgt_d   = tgt_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        up_w    = 1'b0;
        down_w  = 1'b0;
        ready_w = 1'b0;
        busy_w  = 1'b0;
        done_w  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_w = 1'b1;
                if (bus.tgt_valid) begin
                    tgt_d   = bus.tgt;
                    gap_d   = bus.gap;
                    state_d = (bus.tgt == pos_q) ? DONE : STEP;
                end
            end
            STEP: begin
                busy_w = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    // Target is N bits wide, so stepping toward it
                    // can never carry past 0 or all-ones.
                    if (tgt_q > pos_q) begin
                        up_w  = 1'b1;
                        pos_d = pos_q + N'(1);
                    end else if (tgt_q < pos_q) begin
                        down_w = 1'b1;
                        pos_d  = pos_q - N'(1);
                    end
                    if (pos_d == tgt_q) begin
                        state_d = DONE;
                    end else if (gap_q == '0) begin
                        state_d = STEP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = gap_q;
                    end
                end
            end
            WAIT: begin
                busy_w = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q <= GAP_W'(1)) begin
                    state_d = STEP;
                end else begin
                    cnt_d = cnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                done_w  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tgt_ready = ready_w;
    assign bus.up        = up_w;
    assign bus.down      = down_w;
    assign bus.busy      = busy_w;
    assign bus.done      = done_w;
    assign bus.pos       = pos_q;
endmodule

// File: tb/tb_up_down_step_gen.sv
// Directed bench for up_down_step_gen with a per-cycle expectation queue.
// Also tracks a pulse counter per DUT that must mirror pos every cycle.
module tb_up_down_step_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    up_down_step_gen_if #(.N(32), .GAP_W(8)) bus ();
    up_down_step_gen_if #(.N(4), .GAP_W(8)) bus4 ();

    up_down_step_gen #(.N(32), .GAP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    up_down_step_gen #(.N(4), .GAP_W(8)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct packed {
        logic        up;
        logic        down;
        logic        busy;
        logic        done;
        logic        ready;
        logic [31:0] pos;
    } exp_t;

    exp_t  q[$];
    int    errors = 0;
    int    checks = 0;
    int    sel    = 0;
    string tag    = "init";

    logic [31:0] sb;
    logic [3:0]  sb4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb  <= '0;
            sb4 <= '0;
        end else begin
            if (bus.up) sb <= sb + 32'd1;
            else if (bus.down) sb <= sb - 32'd1;
            if (bus4.up) sb4 <= sb4 + 4'd1;
            else if (bus4.down) sb4 <= sb4 - 4'd1;
        end
    end

    always @(negedge clk) begin
        checks++;
        assert (sb === bus.pos) else begin
            errors++;
            $error("FAIL sb_pos obs=%0d exp=%0d", bus.pos, sb);
        end
        checks++;
        assert (sb4 === bus4.pos) else begin
            errors++;
            $error("FAIL sb_pos4 obs=%0d exp=%0d", bus4.pos, sb4);
        end
    end

    function automatic exp_t observe(int s);
        exp_t o;
        if (s != 0) begin
            o.up    = bus4.up;
            o.down  = bus4.down;
            o.busy  = bus4.busy;
            o.done  = bus4.done;
            o.ready = bus4.tgt_ready;
            o.pos   = {28'd0, bus4.pos};
        end else begin
            o.up    = bus.up;
            o.down  = bus.down;
            o.busy  = bus.busy;
            o.done  = bus.done;
            o.ready = bus.tgt_ready;
            o.pos   = bus.pos;
        end
        return o;
    endfunction

    task automatic chk(input exp_t e);
        exp_t o;
        o = observe(sel);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s obs up=%b dn=%b busy=%b done=%b rdy=%b pos=%0d exp up=%b dn=%b busy=%b done=%b rdy=%b pos=%0d",
                   tag, o.up, o.down, o.busy, o.done, o.ready, o.pos,
                   e.up, e.down, e.busy, e.done, e.ready, e.pos);
        end
    endtask

    task automatic push(input logic u, input logic d, input logic b,
                        input logic dn, input logic r, input logic [31:0] p);
        exp_t e;
        e.up    = u;
        e.down  = d;
        e.busy  = b;
        e.done  = dn;
        e.ready = r;
        e.pos   = p;
        q.push_back(e);
    endtask

    // Expected per-cycle trace of a move, starting the cycle after acceptance.
    task automatic plan_move(input logic [31:0] start, input logic [31:0] t,
                             input int g);
        logic [31:0] p;
        p = start;
        while (p != t) begin
            push(t > p, t < p, 1'b1, 1'b0, 1'b0, p);
            p = (t > p) ? p + 32'd1 : p - 32'd1;
            if (p != t) repeat (g) push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, p);
        end
        push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, p);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_n(input int n);
        repeat (n) begin
            step();
            bus.tgt_valid  = 1'b0;
            bus4.tgt_valid = 1'b0;
            bus.tgt        = $urandom;
            bus.gap        = 8'($urandom);
            bus4.tgt       = 4'($urandom);
            bus4.gap       = 8'($urandom);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s obs=queue_empty exp=entry", tag);
            end else begin
                chk(q.pop_front());
            end
        end
    endtask

    task automatic drain_all();
        int n;
        n = q.size();
        drain_n(n);
    endtask

    task automatic req(input int s, input logic [31:0] t, input int g,
                       input logic [31:0] start);
        sel = s;
        if (s != 0) begin
            bus4.tgt_valid = 1'b1;
            bus4.tgt       = t[3:0];
            bus4.gap       = g[7:0];
        end else begin
            bus.tgt_valid = 1'b1;
            bus.tgt       = t;
            bus.gap       = g[7:0];
        end
        plan_move(start, t, g);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        q.delete();
    endtask

    initial begin
        exp_t idle0;
        idle0 = '{up: 1'b0, down: 1'b0, busy: 1'b0, done: 1'b0,
                  ready: 1'b1, pos: 32'd0};
        bus.tgt_valid  = 1'b0;
        bus.tgt        = '0;
        bus.gap        = '0;
        bus.abort      = 1'b0;
        bus4.tgt_valid = 1'b0;
        bus4.tgt       = '0;
        bus4.gap       = '0;
        bus4.abort     = 1'b0;

        step();
        tag = "reset";
        sel = 0;
        chk(idle0);
        sel = 1;
        chk(idle0);
        rst = 1'b0;

        tag = "up3_gap0";
        req(0, 32'd3, 0, 32'd0);
        drain_all();

        tag = "down2_gap2";
        req(0, 32'd1, 2, 32'd3);
        drain_all();

        tag = "tgt_eq_pos";
        req(0, 32'd1, 5, 32'd1);
        drain_all();

        do_reset();
        tag = "abort_move";
        req(0, 32'd10, 1, 32'd0);
        drain_n(8);
        bus.abort = 1'b1;
        q.delete();
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4);
        drain_n(1);
        bus.abort = 1'b0;
        tag = "after_abort";
        req(0, 32'd4, 3, 32'd4);
        drain_all();

        do_reset();
        tag = "rst_mid_move";
        req(0, 32'd8, 0, 32'd0);
        drain_n(5);
        rst = 1'b1;
        #1;
        q.delete();
        chk(idle0);
        step();
        chk(idle0);
        rst = 1'b0;

        do_reset();
        tag = "n4_to14";
        req(1, 32'd14, 0, 32'd0);
        drain_all();
        tag = "n4_to15";
        req(1, 32'd15, 0, 32'd14);
        drain_all();
        tag = "n4_nowrap";
        req(1, 32'd15, 0, 32'd15);
        drain_all();

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/up_down_step_gen.md
UP_DOWN_STEP_GEN -- requirements
Module: up_down_step_gen

Interface
REQ-001 Parameter N, default 32: width of target and position, matching the width of the up/down counter this block drives.
REQ-002 Parameter GAP_W, default 8: width of the inter-step gap field.
REQ-003 Clk  input  1  clock; all state updates on the rising edge.
REQ-004 Rst  input  1  reset; asynchronous, active-high.
REQ-005 Tgt_valid  input  1  a target request is presented.
REQ-006 Tgt_ready  output  1  the block can accept a target request.
REQ-007 Tgt  input  N  target position, unsigned.
REQ-008 Gap  input  GAP_W  number of idle cycles between consecutive step pulses.
REQ-009 Abort  input  1  cancels the move in progress.
REQ-010 Up  output  1  one-cycle increment pulse to the counter.
REQ-011 Down  output  1  one-cycle decrement pulse to the counter.
REQ-012 Pos  output  N  mirror of the counter value (the number of Up pulses minus Down pulses issued since reset).
REQ-013 Busy  output  1  a move is in progress.
REQ-014 Done  output  1  one-cycle pulse when a move completes at its target.

Function
REQ-015 The block SHALL implement four states: IDLE, STEP, WAIT and DONE.
REQ-016 Tgt_ready SHALL be 1 only in IDLE; Busy SHALL be 1 only in STEP and WAIT.
REQ-017 A request SHALL be accepted on an edge where Tgt_valid=1 and Tgt_ready=1; Tgt and Gap SHALL be captured into internal registers at that edge.
REQ-018 On acceptance, the block SHALL go to DONE if the captured Tgt equals Pos, and to STEP otherwise.
REQ-019 In STEP, the block SHALL drive Up=1 if target>Pos and Down=1 if target<Pos (unsigned compare) for exactly that cycle.
REQ-020 Pos SHALL increment or decrement at the edge that ends the STEP cycle.
REQ-021 Up and Down SHALL never both be 1 in the same cycle, and SHALL be 0 in every state other than STEP.
REQ-022 Pos SHALL never wrap: a move toward target 0 or target 2^N-1 SHALL stop exactly at that value.
REQ-023 After a STEP, the block SHALL go to DONE if the updated Pos equals the target.
REQ-024 Otherwise, after a STEP, the block SHALL go to STEP again if the captured Gap is 0 (back-to-back pulses), and to WAIT otherwise.
REQ-025 In WAIT, the block SHALL hold Up=Down=0 for exactly Gap cycles, using an internal down-counter loaded at the STEP edge, then go to STEP.
REQ-026 First-pulse latency SHALL be one cycle: for acceptance at edge k, Up or Down is high in the cycle following edge k.
REQ-027 In DONE, Done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-028 If Abort=1 in STEP or WAIT, the block SHALL suppress the pulse in that cycle, leave Pos unchanged, go to IDLE and not assert Done.
REQ-029 Abort SHALL be ignored in IDLE and DONE.
REQ-030 Tgt, Gap and Tgt_valid SHALL be ignored while Tgt_ready=0, and changes to them during a move SHALL not affect that move.
REQ-031 The pulse period SHALL be Gap+1 cycles, and a move of distance D SHALL take D*(Gap+1)-Gap cycles from the first pulse to the last pulse.

Reset
REQ-032 While Rst=1, the outputs SHALL be: state IDLE, Pos=0, Up=0, Down=0, Busy=0, Done=0, Tgt_ready=1.
REQ-033 The internal target and gap registers SHALL reset to 0.
REQ-034 Rst asserted mid-move SHALL abort the move immediately, with no further pulse issued and no Done.
REQ-035 After Rst deasserts, the first request SHALL be accepted on the first rising edge with Tgt_valid=1.

Verification
REQ-036 The bench SHALL check: reset, then Tgt=3, Gap=0 -> Up high for 3 consecutive cycles starting 1 cycle after acceptance; Pos=3; Done one cycle later; Tgt_ready back to 1.
REQ-037 The bench SHALL check: from Pos=3, Tgt=1, Gap=2 -> two Down pulses 3 cycles apart; Pos=1; Done once; Up stays 0 throughout.
REQ-038 The bench SHALL check: Tgt equal to Pos (Tgt=1 with Pos=1) -> no pulse; Done in the cycle after acceptance; Busy stays 0.
REQ-039 The bench SHALL check: Tgt=10, Gap=1, Abort after the 4th Up pulse -> Pos=4; no Done; Tgt_ready=1 on the next cycle; a following request Tgt=4 -> immediate Done.
REQ-040 The bench SHALL check: Rst asserted mid-move (Tgt=8, Gap=0, after 5 pulses) -> Pos=0, Up=0 and Busy=0 at once, with no Done.
REQ-041 The bench SHALL check: N=4 and Tgt=15 from Pos=14 -> one Up pulse; Pos=15; Done; then Tgt=15 again -> no pulse and no wrap.
REQ-042 Throughout all tests, a scoreboard counter driven by Up and Down SHALL equal Pos on every cycle.
